// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display: 7-segment table (active-low, bit 0 = a .. bit 6 = g),
// blank code and reset code.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t BlankCode = 7'h7F;
  localparam seg_t ResetCode = 7'h40;

  // Entry 15 first so that SegTable[n] is the pattern for nibble n.
  localparam logic [15:0][6:0] SegTable = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-low 7-segment decoder.
module hex7seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegTable[nibble_i];
  end

endmodule

// File: rtl/hex_display_n.sv
// N-digit registered hex display with load/ack capture, leading-zero blanking and per-digit
// blink driven by a free-running prescaler.
module hex_display_n
  import hex_display_pkg::*;
#(
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic                  Blank_lz,
  input  logic [DIGITS-1:0]     Blink_mask,
  output logic                  Ack,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int unsigned PW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] PrescMax = PW'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] value_q, value_d;
  logic                blank_lz_q, blank_lz_d;
  logic [DIGITS-1:0]   blink_mask_q, blink_mask_d;
  logic                ack_q, ack_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                phase_q, phase_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;

  logic [DIGITS-1:0][6:0] seg;
  logic [DIGITS-1:0]      blank;

  always_comb begin
    value_d      = Load ? Value : value_q;
    blank_lz_d   = Load ? Blank_lz : blank_lz_q;
    blink_mask_d = Load ? Blink_mask : blink_mask_q;
    ack_d        = Load;
  end

  // A capture restarts the blink cycle in the visible phase, even on a wrap edge.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    if (Load || (blink_mask_q == '0)) begin
      presc_d = '0;
      phase_d = 1'b1;
    end else if (presc_q == PrescMax) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
    hex7seg_decode u_dec (
      .nibble_i (value_q[4*g +: 4]),
      .seg_o    (seg[g])
    );
  end

  // Walk from the most significant digit down, tracking whether everything above is zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (value_q[4*i +: 4] == 4'h0);
      if ((i > 0) && blank_lz_q && zero_run) blank[i] = 1'b1;
      if (blink_mask_q[i] && !phase_q) blank[i] = 1'b1;
    end
  end

  always_comb begin
    hex_d = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      hex_d[7*i +: 7] = blank[i] ? BlankCode : seg[i];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      value_q      <= '0;
      blank_lz_q   <= 1'b0;
      blink_mask_q <= '0;
      ack_q        <= 1'b0;
      presc_q      <= '0;
      phase_q      <= 1'b1;
      hex_q        <= {DIGITS{ResetCode}};
    end else begin
      value_q      <= value_d;
      blank_lz_q   <= blank_lz_d;
      blink_mask_q <= blink_mask_d;
      ack_q        <= ack_d;
      presc_q      <= presc_d;
      phase_q      <= phase_d;
      hex_q        <= hex_d;
    end
  end

  assign Ack = ack_q;
  assign HEX = hex_q;

endmodule

// File: tb/tb_hex_display_n.sv
// Directed self-checking bench for hex_display_n with DIGITS=6 and a short blink period.
module tb_hex_display_n;

  localparam int unsigned DIGITS    = 6;
  localparam int unsigned BLINK_DIV = 4;

  logic        Clock      = 1'b0;
  logic        Reset      = 1'b0;
  logic        Load       = 1'b0;
  logic [23:0] Value      = '0;
  logic        Blank_lz   = 1'b0;
  logic [5:0]  Blink_mask = '0;
  logic        Ack;
  logic [41:0] HEX;

  int checks   = 0;
  int failures = 0;

  localparam logic [41:0] AllZero = {6{7'h40}};

  hex_display_n #(
    .DIGITS    (DIGITS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Load       (Load),
    .Value      (Value),
    .Blank_lz   (Blank_lz),
    .Blink_mask (Blink_mask),
    .Ack        (Ack),
    .HEX        (HEX)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Presents one capture edge, then drops Load.
  task automatic do_load(input logic [23:0] v, input logic lz, input logic [5:0] m);
    Value      = v;
    Blank_lz   = lz;
    Blink_mask = m;
    Load       = 1'b1;
    step();
    Load       = 1'b0;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (HEX !== AllZero) begin
      failures++; $display("FAIL reset_hex: got %h expected %h", HEX, AllZero);
    end
    checks++;
    if (Ack !== 1'b0) begin
      failures++; $display("FAIL reset_ack: got %b expected 0", Ack);
    end
    Value = 24'h123456;
    Load  = 1'b1;
    step();
    step();
    checks++;
    if (Ack !== 1'b0 || HEX !== AllZero) begin
      failures++; $display("FAIL load_under_reset: ack %b hex %h expected 0 / %h", Ack, HEX, AllZero);
    end
    #2 Reset = 1'b0;
    step();
    checks++;
    if (Ack !== 1'b1) begin
      failures++; $display("FAIL first_capture_ack: got %b expected 1", Ack);
    end
    Load = 1'b0;
    step();
    checks++;
    if (HEX !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
      failures++; $display("FAIL first_capture_hex: got %h expected %h", HEX,
                           {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    end
  endtask

  task automatic test_table();
    logic [23:0] vals [3];
    logic [41:0] exps [3];
    vals[0] = 24'hFEDCBA; exps[0] = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08};
    vals[1] = 24'h987654; exps[1] = {7'h18, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19};
    vals[2] = 24'h000321; exps[2] = {7'h40, 7'h40, 7'h40, 7'h30, 7'h24, 7'h79};
    for (int k = 0; k < 3; k++) begin
      do_load(vals[k], 1'b0, 6'b0);
      checks++;
      if (Ack !== 1'b1) begin
        failures++; $display("FAIL table_ack_%0d: got %b expected 1", k, Ack);
      end
      step();
      checks++;
      if (Ack !== 1'b0) begin
        failures++; $display("FAIL table_ack_drop_%0d: got %b expected 0", k, Ack);
      end
      checks++;
      if (HEX !== exps[k]) begin
        failures++; $display("FAIL table_hex_%0d: got %h expected %h", k, HEX, exps[k]);
      end
      step();
      checks++;
      if (Ack !== 1'b0 || HEX !== exps[k]) begin
        failures++; $display("FAIL table_hold_%0d: ack %b hex %h expected 0 / %h", k, Ack, HEX,
                             exps[k]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [23:0] vals [3];
    logic [41:0] exps [3];
    vals[0] = 24'h000A00; exps[0] = {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40};
    vals[1] = 24'h000000; exps[1] = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vals[2] = 24'h100000; exps[2] = {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    for (int k = 0; k < 3; k++) begin
      do_load(vals[k], 1'b1, 6'b0);
      step();
      checks++;
      if (HEX !== exps[k]) begin
        failures++; $display("FAIL lz_hex_%0d: got %h expected %h", k, HEX, exps[k]);
      end
    end
  endtask

  task automatic test_blink();
    logic [41:0] vis;
    logic [41:0] blk;
    logic [41:0] exp_h;
    vis = {{5{7'h40}}, 7'h79};
    blk = {{5{7'h40}}, 7'h7F};
    do_load(24'h000001, 1'b0, 6'b000001);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_h = (((k - 1) / 4) % 2 == 0) ? vis : blk;
      checks++;
      if (HEX !== exp_h) begin
        failures++; $display("FAIL blink_cycle_%0d: got %h expected %h", k, HEX, exp_h);
      end
    end
  endtask

  task automatic test_load_at_wrap();
    logic [41:0] vis;
    int bad;
    vis = {{5{7'h40}}, 7'h24};
    bad = 0;
    do_load(24'h000001, 1'b0, 6'b000001);
    step();
    step();
    step();
    // The next edge is the prescaler wrap edge.
    do_load(24'h000002, 1'b0, 6'b000001);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (HEX !== vis) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL wrap_load_visible: got %0d bad cycles, last %h expected 0 / %h",
                           bad, HEX, vis);
    end
    step();
    checks++;
    if (HEX !== {{5{7'h40}}, 7'h7F}) begin
      failures++; $display("FAIL wrap_load_blank: got %h expected %h", HEX, {{5{7'h40}}, 7'h7F});
    end
  endtask

  task automatic test_reset_mid_blink();
    int bad;
    bad = 0;
    do_load(24'h000001, 1'b0, 6'b000001);
    for (int k = 0; k < 5; k++) step();
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (HEX !== AllZero || Ack !== 1'b0) begin
      failures++; $display("FAIL reset_mid_blink: hex %h ack %b expected %h / 0", HEX, Ack, AllZero);
    end
    #2 Reset = 1'b0;
    Load = 1'b1;
    step();
    Load = 1'b0;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Ack !== 1'b0) begin
      failures++; $display("FAIL reset_clears_ack: got %b expected 0", Ack);
    end
    #2 Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (HEX !== AllZero || Ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL post_reset_steady: got %0d bad cycles, last %h expected %h", bad,
                           HEX, AllZero);
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_leading_zero();
    test_blink();
    test_load_at_wrap();
    test_reset_mid_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
